// File: rtl/joy_serial_scan.sv
// ---------------------------------------------------------------------------
// joy_serial_scan
//
// Scans a 32-bit parallel-in/serial-out shift-register chain (two 16-button
// joystick adapters) and presents debounced-by-frame, active-high button
// vectors. All FSM and pin activity is paced by a tick derived from clk, so
// the chain sees a slow, clean shift clock.
//
// Frame: GAP_TICKS idle ticks, one LOAD tick (JOY_LOAD low), then 32 bits of
// two ticks each (JOY_CLK low then high). Results are committed on the last
// tick of the frame; frame_valid is high in the first cycle the new values
// are visible.
//
// Parameters
//   CLK_DIV    clk cycles per tick (2..255)
//   GAP_TICKS  idle ticks between frames (1..255)
//
// Ports
//   clk          single clock
//   reset        asynchronous, active-high
//   JOY_DATA     serial data from the chain, active-low buttons, async
//   JOY_CLK      shift clock to the chain (chain shifts on rising edge)
//   JOY_LOAD     parallel-load strobe to the chain, active-low
//   joystick1    player 1 buttons, active-high, bit 0 = first serial bit
//   joystick2    player 2 buttons, active-high
//   present      adapter detected (last frame was not all-zero on the line)
//   frame_valid  one-cycle pulse when joystick1/joystick2/present update
// ---------------------------------------------------------------------------
module joy_serial_scan #(
    parameter int CLK_DIV   = 24,
    parameter int GAP_TICKS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        present,
    output logic        frame_valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);

    logic [1:0]  sync_reg;
    logic        data_sync;
    logic [7:0]  div_reg;
    logic        tick;
    logic [1:0]  state_reg;
    logic [7:0]  gap_reg;
    logic [4:0]  index_reg;
    logic        phase_reg;
    logic [31:0] raw_reg;
    logic        capture;

    // Two-flop synchronizer. Resets to 1 so an idle (released) line is
    // what the sampler sees until real data has propagated through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], JOY_DATA};
        end
    end

    assign data_sync = sync_reg[1];

    // Free-running tick divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg <= 8'd0;
        end else if (div_reg == DIV_LAST) begin
            div_reg <= 8'd0;
        end else begin
            div_reg <= div_reg + 8'd1;
        end
    end

    assign tick = (div_reg == DIV_LAST);

    // A bit is captured on the phase-0 tick, i.e. at the same edge that
    // raises JOY_CLK; the chain has held this bit stable for a full tick.
    assign capture = tick && (state_reg == ST_SHIFT) && !phase_reg;

    // Per-bit capture flops: each raw bit only loads when the index points
    // at it, so the register never needs a shift path.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_raw
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    raw_reg[gi] <= 1'b0;
                end else if (capture && (index_reg == 5'(gi))) begin
                    raw_reg[gi] <= data_sync;
                end
            end
        end
    endgenerate

    // Scan FSM. Pins and outputs are flops updated only on tick cycles
    // (frame_valid is the one exception: it self-clears the cycle after).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            gap_reg     <= 8'd0;
            index_reg   <= 5'd0;
            phase_reg   <= 1'b0;
            JOY_CLK     <= 1'b0;
            JOY_LOAD    <= 1'b1;
            joystick1   <= 16'd0;
            joystick2   <= 16'd0;
            present     <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (tick) begin
                case (state_reg)
                    ST_IDLE: begin
                        JOY_CLK <= 1'b0;
                        if (gap_reg == GAP_LAST) begin
                            gap_reg   <= 8'd0;
                            JOY_LOAD  <= 1'b0;
                            state_reg <= ST_LOAD;
                        end else begin
                            gap_reg  <= gap_reg + 8'd1;
                            JOY_LOAD <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        JOY_LOAD  <= 1'b1;
                        index_reg <= 5'd0;
                        phase_reg <= 1'b0;
                        state_reg <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (!phase_reg) begin
                            JOY_CLK   <= 1'b1;
                            phase_reg <= 1'b1;
                        end else begin
                            JOY_CLK   <= 1'b0;
                            phase_reg <= 1'b0;
                            if (index_reg == 5'd31) begin
                                // An all-zero frame means no adapter or a
                                // line stuck low: report nothing pressed.
                                if (raw_reg == 32'd0) begin
                                    joystick1 <= 16'd0;
                                    joystick2 <= 16'd0;
                                    present   <= 1'b0;
                                end else begin
                                    joystick1 <= ~raw_reg[15:0];
                                    joystick2 <= ~raw_reg[31:16];
                                    present   <= 1'b1;
                                end
                                frame_valid <= 1'b1;
                                state_reg   <= ST_IDLE;
                            end else begin
                                index_reg <= index_reg + 5'd1;
                            end
                        end
                    end
                    default: begin
                        JOY_CLK   <= 1'b0;
                        JOY_LOAD  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_joy_serial_scan.sv
// ---------------------------------------------------------------------------
// tb_joy_serial_scan
//
// Two instances: one at default parameters (functional frame checks against
// a button-level model of the chain) and one at CLK_DIV=2, GAP_TICKS=1
// (pin timing measured by a monitor). Each chain model is "live": the bit on
// JOY_DATA is always ~buttons[ptr], ptr clears while JOY_LOAD is low and
// advances on each JOY_CLK rising edge.
// ---------------------------------------------------------------------------
module tb_joy_serial_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- DUT A: defaults ----------------
    logic        joy_data_a, jclk_a, jload_a, present_a, fv_a;
    logic [15:0] j1_a, j2_a;

    joy_serial_scan dut_a (
        .clk        (clk),
        .reset      (rst),
        .JOY_DATA   (joy_data_a),
        .JOY_CLK    (jclk_a),
        .JOY_LOAD   (jload_a),
        .joystick1  (j1_a),
        .joystick2  (j2_a),
        .present    (present_a),
        .frame_valid(fv_a)
    );

    // ---------------- DUT B: fast ----------------
    logic        joy_data_b, jclk_b, jload_b, present_b, fv_b;
    logic [15:0] j1_b, j2_b;

    joy_serial_scan #(.CLK_DIV(2), .GAP_TICKS(1)) dut_b (
        .clk        (clk),
        .reset      (rst),
        .JOY_DATA   (joy_data_b),
        .JOY_CLK    (jclk_b),
        .JOY_LOAD   (jload_b),
        .joystick1  (j1_b),
        .joystick2  (j2_b),
        .present    (present_b),
        .frame_valid(fv_b)
    );

    // ---------------- chain models ----------------
    logic [31:0] buttons_a = 32'd0;
    logic [31:0] buttons_b = 32'd0;
    logic        zero_a    = 1'b0;
    logic [5:0]  ptr_a     = 6'd0;
    logic [5:0]  ptr_b     = 6'd0;
    logic        pj_a      = 1'b0;
    logic        pj_bc     = 1'b0;

    always @(negedge clk) begin
        if (!jload_a) ptr_a <= 6'd0;
        else if (jclk_a && !pj_a && ptr_a < 6'd32) ptr_a <= ptr_a + 6'd1;
        pj_a <= jclk_a;
        if (!jload_b) ptr_b <= 6'd0;
        else if (jclk_b && !pj_bc && ptr_b < 6'd32) ptr_b <= ptr_b + 6'd1;
        pj_bc <= jclk_b;
    end

    assign joy_data_a = zero_a ? 1'b0 : ((ptr_a < 6'd32) ? ~buttons_a[ptr_a[4:0]] : 1'b1);
    assign joy_data_b = (ptr_b < 6'd32) ? ~buttons_b[ptr_b[4:0]] : 1'b1;

    // Expected {present, joystick2, joystick1} for a frame in which the
    // chain reported the given pressed buttons. Everything pressed is
    // indistinguishable from a dead line, so it reads as "absent".
    function automatic logic [32:0] model(input logic [31:0] pressed);
        if (pressed == 32'hFFFF_FFFF) return 33'd0;
        return {1'b1, pressed};
    endfunction

    // ---------------- invariant monitors ----------------
    int          stray_a = 0;
    int          clash   = 0;
    logic [15:0] j1_prev = 16'd0;
    logic [15:0] j2_prev = 16'd0;

    always @(negedge clk) begin
        if (!rst && ((j1_a !== j1_prev) || (j2_a !== j2_prev)) && !fv_a)
            stray_a <= stray_a + 1;
        if ((jclk_a && !jload_a) || (jclk_b && !jload_b))
            clash <= clash + 1;
        j1_prev <= j1_a;
        j2_prev <= j2_a;
    end

    // ---------------- timing monitor for DUT B ----------------
    int   cyc_b, hi_run, lo_run, rises, loads, last_fv, first_fv, first_load;
    int   period_b, frame_rises, frame_loads, hi_min, hi_max, lo_min, lo_max, frames_b;
    logic pj_b, pl_b;

    always @(negedge clk) begin
        if (rst) begin
            cyc_b <= 0; hi_run <= 0; lo_run <= 0; rises <= 0; loads <= 0;
            last_fv <= 0; first_fv <= 0; first_load <= 0; period_b <= 0;
            frame_rises <= 0; frame_loads <= 0; frames_b <= 0;
            hi_min <= 1000; hi_max <= 0; lo_min <= 1000; lo_max <= 0;
            pj_b <= 1'b0; pl_b <= 1'b1;
        end else begin
            cyc_b <= cyc_b + 1;
            pj_b  <= jclk_b;
            pl_b  <= jload_b;
            if (jclk_b) hi_run <= hi_run + 1;
            else if (pj_b) begin
                hi_run <= 0;
                if (hi_run < hi_min) hi_min <= hi_run;
                if (hi_run > hi_max) hi_max <= hi_run;
            end
            if (!jload_b) lo_run <= lo_run + 1;
            else if (!pl_b) begin
                lo_run <= 0;
                if (lo_run < lo_min) lo_min <= lo_run;
                if (lo_run > lo_max) lo_max <= lo_run;
            end
            if (!jload_b && pl_b && first_load == 0) first_load <= cyc_b + 1;
            if (fv_b) begin
                frames_b <= frames_b + 1;
                if (frames_b == 0) first_fv <= cyc_b + 1;
                else period_b <= cyc_b + 1 - last_fv;
                last_fv     <= cyc_b + 1;
                frame_rises <= rises;
                frame_loads <= loads;
                rises       <= 0;
                loads       <= 0;
            end else begin
                if (jclk_b && !pj_b) rises <= rises + 1;
                if (!jload_b && pl_b) loads <= loads + 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // which: 0 = JOY_LOAD low on A, 1 = frame_valid on A
    task automatic wait_for(input int which, input int limit, output int n);
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            hit = (which == 0) ? (jload_a === 1'b0) : (fv_a === 1'b1);
        end
        chk("wait_reached", hit, 1'b1);
    endtask

    task automatic wait_ptr(input logic [5:0] v);
        int n;
        n = 0;
        while (ptr_a !== v && n < 4000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ptr_reached", ptr_a, v);
    endtask

    task automatic chk_frame_a(input string tag, input logic [31:0] pressed);
        logic [32:0] e;
        e = model(pressed);
        chk({tag, "_j1"}, j1_a, e[15:0]);
        chk({tag, "_j2"}, j2_a, e[31:16]);
        chk({tag, "_present"}, present_a, e[32]);
        $display("frame %s: j1=%h j2=%h present=%b", tag, j1_a, j2_a, present_a);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, m;
        logic [31:0] old_p, new_p, mix;
        logic [32:0] eb;

        buttons_b = $urandom;
        repeat (3) @(negedge clk);
        chk("rst_j1_a", j1_a, 16'd0);
        chk("rst_j2_a", j2_a, 16'd0);
        chk("rst_present_a", present_a, 1'b0);
        chk("rst_fv_a", fv_a, 1'b0);
        chk("rst_load_a", jload_a, 1'b1);
        chk("rst_clk_a", jclk_a, 1'b0);
        chk("rst_load_b", jload_b, 1'b1);
        #2 rst = 1'b0;

        // First LOAD on the 16th tick, first commit 65 ticks later.
        wait_for(0, 1000, n);
        chk("first_load_cycles", n, 384);
        wait_for(1, 3000, m);
        chk("first_commit_cycles", n + m, 1944);
        chk_frame_a("idle", buttons_a);

        wait_for(1, 3000, n);
        chk("period_idle", n, 1944);

        for (int i = 0; i < 4; i++) begin
            buttons_a = $urandom;
            wait_for(1, 3000, n);
            chk("period_rand", n, 1944);
            chk_frame_a("rand", buttons_a);
        end

        buttons_a = 32'h0002_0001;
        wait_for(1, 3000, n);
        chk_frame_a("bit0_bit17", buttons_a);

        zero_a = 1'b1;
        wait_for(1, 3000, n);
        chk("period_zero", n, 1944);
        chk_frame_a("line_low", 32'hFFFF_FFFF);
        zero_a = 1'b0;

        // Pattern swap once bit 8 is on the line.
        old_p     = $urandom & 32'h7FFF_FFFF;
        buttons_a = old_p;
        wait_for(1, 3000, n);
        chk_frame_a("pre_mix", old_p);
        new_p = $urandom;
        wait_ptr(6'd8);
        buttons_a = new_p;
        chk("mid_frame_hold_j1", j1_a, model(old_p) & 33'hFFFF);
        wait_for(1, 3000, n);
        mix = {new_p[31:8], old_p[7:0]};
        chk_frame_a("mix", mix);

        // Fast instance timing.
        eb = model(buttons_b);
        chk("b_first_load", first_load, 2);
        chk("b_first_fv", first_fv, 132);
        chk("b_period", period_b, 132);
        chk("b_clk_high_min", hi_min, 2);
        chk("b_clk_high_max", hi_max, 2);
        chk("b_rises", frame_rises, 32);
        chk("b_loads", frame_loads, 1);
        chk("b_load_low_min", lo_min, 2);
        chk("b_load_low_max", lo_max, 2);
        chk("b_frames", frames_b > 100, 1'b1);
        chk("b_j1", j1_b, eb[15:0]);
        chk("b_j2", j2_b, eb[31:16]);
        chk("b_present", present_b, eb[32]);
        $display("fast: period=%0d rises=%0d hi=%0d..%0d", period_b, frame_rises, hi_min, hi_max);

        // Reset in the middle of a shift.
        buttons_a = ($urandom & 32'h7FFF_FFFF) | 32'h1;
        wait_for(1, 3000, n);
        chk_frame_a("pre_reset", buttons_a);
        wait_ptr(6'd20);
        rst = 1'b1;
        #1;
        chk("mid_rst_j1", j1_a, 16'd0);
        chk("mid_rst_j2", j2_a, 16'd0);
        chk("mid_rst_present", present_a, 1'b0);
        chk("mid_rst_load", jload_a, 1'b1);
        chk("mid_rst_clk", jclk_a, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        buttons_a = $urandom;
        wait_for(1, 3000, n);
        chk("post_rst_commit_cycles", n, 1944);
        chk_frame_a("post_rst", buttons_a);

        @(negedge clk);
        chk("stray_output_changes", stray_a, 0);
        chk("clk_high_during_load", clash, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
